spi_mem_reader_mc: RTL
======================

# spi_mem_reader_mc

Multi-channel, parametrised SPI memory reader for the DSO capture path. It streams NCH interleaved sample channels out of a synchronous capture RAM over the SPI bitstream. Each word is DW bits wide and goes out MSB first. The block walks a programmable address window, and it generates the RAM address itself with the RAM read latency built in. It sits between the SPI front end (which supplies the sel/rising/falling strobes) and the capture memory. It handles more than one channel and more than 16-bit words, and it has a bounded address window, end-of-window handling and overrun detection.

## Interface
Parameters:
- AW, 12: RAM address width.
- DW, 16: word width, in bits shifted per word; at least 2.
- NCH, 2: channels per address, at least 1; the channel index width CHW = max(1, $clog2(NCH)) is local.

Ports:
- clk  in  1  system clock, the only clock.
- reset_flag  in  1  synchronous, active-high reset; also used as the per-transaction restart.
- sel  in  1  SPI chip select, active high; rising and falling are ignored while it is low.
- rising  in  1  one-clk strobe for an SCK rising edge; reserved, not used for shifting.
- falling  in  1  one-clk strobe for an SCK falling edge; shifts the next bit out.
- start_addr  in  AW  first address of the window; sampled when reset_flag is high.
- last_addr  in  AW  final address of the window; sampled when reset_flag is high.
- data  in  NCH*DW  RAM read word; channel k occupies bits [k*DW +: DW]; valid one clk after addr changes.
- addr  out  AW  RAM read address.
- ch  out  CHW  current channel index.
- so  out  1  serial data out, MSB first.
- word_strobe  out  1  one-clk pulse after the last bit of each word has been shifted.
- done  out  1  window exhausted; meaningful only without wrap.
- overrun  out  1  sticky; a falling strobe arrived while a fetch was in progress.

## Operation
- State machine states: FETCH1, FETCH2, SHIFT, DONE.
- reset_flag (overrides everything, including a simultaneous falling):
  - addr <= start_addr, ch <= 0;
  - latch start_addr and last_addr into internal window registers;
  - bit counter <= DW-1, shift register <= 0;
  - word_strobe <= 0, done <= 0, overrun <= 0;
  - state <= FETCH1.
- FETCH1 -> FETCH2 unconditionally. This spends the cycle for the RAM read.
- FETCH2 -> SHIFT:
  - shift register <= data[ch*DW +: DW];
  - bit counter <= DW-1.
- SHIFT:
  - so = shift register MSB.
  - On sel & falling, shift left with zero fill and decrement the bit counter.
  - When sel & falling arrives with the bit counter at 0, the word is complete:
    - word_strobe <= 1, then advance position as described below;
    - state <= FETCH1, or DONE if the window is exhausted.
- Advance order: channels first, then address.
  - If ch < NCH-1: ch <= ch+1 and addr is unchanged.
  - Otherwise ch <= 0 and addr <= addr+1, modulo 2^AW.
  - When addr equals the latched last_addr and ch is NCH-1, end-of-window handling applies (see Configuration).
- If start_addr > last_addr, addr counts up through 2^AW-1 and wraps to 0 before reaching last_addr.
- A sel & falling strobe in FETCH1 or FETCH2 is discarded: no shift, no counter change, and overrun <= 1.
- DONE: so = 0, and falling is ignored without setting overrun. Only reset_flag leaves this state.
- rising is never used for shifting. In SHIFT, so is guaranteed stable on every rising strobe.

## Timing
- Reset edge E0 (reset_flag high):
  - addr and ch take their new values after E0;
  - FETCH2 at E1, with RAM data becoming valid after E1;
  - the shift register loads at E2, and so shows data MSB after E2.
- Word boundary at edge W (the DW-th falling edge):
  - word_strobe is high for one clk after W;
  - addr/ch are updated after W, and the next word is loaded at W+2.
- SPI front-end constraint: at least 3 clk between the falling strobe that completes a word and the next falling strobe. Violating it sets overrun.
- Reset values after any reset_flag cycle: addr = start_addr, ch = 0, so = 0, word_strobe = 0, done = 0, overrun = 0.
- reset_flag in the middle of a word aborts that word immediately. No word_strobe is emitted for it.

## Configuration
- SPI_MEM_READER_WRAP_EN defined:
  - at the end of the window, addr <= latched start_addr and ch <= 0, then FETCH1;
  - streaming continues indefinitely, and done stays 0.
- SPI_MEM_READER_WRAP_EN undefined:
  - at the end of the window, state <= DONE and done <= 1, with addr and ch held;
  - done stays high until reset_flag.

## Test plan
- Basic stream: AW=4, DW=16, NCH=2, start=0, last=1, RAM[a] = {16'hB0+a, 16'hA0+a}, 4 words clocked. Required so sequence: 0x00A0, 0x00B0, 0x00A1, 0x00B1, MSB first; word_strobe pulses four times; addr sequence 0,0,1,1.
- End of window: after the 4th word, without WRAP_EN done=1, addr=1, and so stays 0 on 16 further falling strobes. With WRAP_EN the 5th word is 0x00A0 and addr=0.
- Overrun: issue falling one clk after a word boundary. Required: overrun=1, that strobe is not shifted, and the next word still begins with its MSB.
- Reset mid-word: assert reset_flag after 7 bits. Required: no word_strobe; after 3 clk, so = MSB of the channel-0 word at start_addr; overrun=0.
- Address rollover: start=4'hE, last=4'h1, NCH=1. Required addr order: E, F, 0, 1, then done.
- sel low: falling strobes with sel=0 cause no shift and no overrun; so holds its value.

Source files
------------

// File: rtl/spi_mem_reader_mc.sv
// Multi-channel SPI memory reader: streams NCH interleaved DW-bit words MSB first from a sync RAM.
// Define SPI_MEM_READER_WRAP_EN to restart at the window start instead of stopping at its end.
module spi_mem_reader_mc #(
  parameter int unsigned AW  = 12,
  parameter int unsigned DW  = 16,
  parameter int unsigned NCH = 2,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset_flag,
  input  logic              sel,
  input  logic              rising,
  input  logic              falling,
  input  logic [AW-1:0]     start_addr,
  input  logic [AW-1:0]     last_addr,
  input  logic [NCH*DW-1:0] data,
  output logic [AW-1:0]     addr,
  output logic [CHW-1:0]    ch,
  output logic              so,
  output logic              word_strobe,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned BCW = $clog2(DW);
  localparam logic [CHW-1:0] ChLast = CHW'(NCH - 1);
  localparam logic [BCW-1:0] BitTop = BCW'(DW - 1);

  typedef enum logic [1:0] {StFetch1, StFetch2, StShift, StDone} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [AW-1:0]  start_q, last_q;
  logic [BCW-1:0] bitcnt_q, bitcnt_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic           word_strobe_q, word_strobe_d;
  logic           done_q, done_d;
  logic           overrun_q, overrun_d;
  logic           shift_en;

  // Shifting is driven only by falling strobes; rising is intentionally unused.
  logic unused_rising;
  assign unused_rising = rising;

`ifndef SPI_MEM_READER_WRAP_EN
  logic unused_start;
  assign unused_start = ^start_q;
`endif

  assign shift_en = sel & falling;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    ch_d          = ch_q;
    bitcnt_d      = bitcnt_q;
    shreg_d       = shreg_q;
    word_strobe_d = 1'b0;
    done_d        = done_q;
    overrun_d     = overrun_q;
    unique case (state_q)
      StFetch1: begin
        state_d = StFetch2;
        if (shift_en) overrun_d = 1'b1;
      end
      StFetch2: begin
        shreg_d  = data[ch_q*DW +: DW];
        bitcnt_d = BitTop;
        state_d  = StShift;
        if (shift_en) overrun_d = 1'b1;
      end
      StShift: begin
        if (shift_en) begin
          shreg_d  = {shreg_q[DW-2:0], 1'b0};
          bitcnt_d = bitcnt_q - 1'b1;
          if (bitcnt_q == '0) begin
            word_strobe_d = 1'b1;
            bitcnt_d      = BitTop;
            state_d       = StFetch1;
            if (ch_q != ChLast) begin
              ch_d = ch_q + 1'b1;
            end else if (addr_q == last_q) begin
`ifdef SPI_MEM_READER_WRAP_EN
              addr_d = start_q;
              ch_d   = '0;
`else
              state_d = StDone;
              done_d  = 1'b1;
`endif
            end else begin
              ch_d   = '0;
              addr_d = addr_q + 1'b1;
            end
          end
        end
      end
      StDone: ;
      default: state_d = StFetch1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_flag) begin
      state_q       <= StFetch1;
      addr_q        <= start_addr;
      ch_q          <= '0;
      start_q       <= start_addr;
      last_q        <= last_addr;
      bitcnt_q      <= BitTop;
      shreg_q       <= '0;
      word_strobe_q <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ch_q          <= ch_d;
      bitcnt_q      <= bitcnt_d;
      shreg_q       <= shreg_d;
      word_strobe_q <= word_strobe_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign addr        = addr_q;
  assign ch          = ch_q;
  assign so          = (state_q == StShift) & shreg_q[DW-1];
  assign word_strobe = word_strobe_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule
